// File: rtl/time_alarm_counter_if.sv
// rtl/time_alarm_counter_if.sv - pulse inputs and time/alarm outputs of time_alarm_counter
interface time_alarm_counter_if;
   logic       up_clock60;
   logic       up_alarm60;
   logic       up_clock_h;
   logic       up_alarm_h;
   logic       min;
   logic       alarm_en;
   logic       stop;
   logic       snooze;
   logic [5:0] clk_min;
   logic [4:0] clk_hour;
   logic [5:0] alm_min;
   logic [4:0] alm_hour;
   logic       ring;
   logic       snoozing;

   modport master (
      output up_clock60, up_alarm60, up_clock_h, up_alarm_h,
      output min, alarm_en, stop, snooze,
      input  clk_min, clk_hour, alm_min, alm_hour, ring, snoozing
   );

   modport slave (
      input  up_clock60, up_alarm60, up_clock_h, up_alarm_h,
      input  min, alarm_en, stop, snooze,
      output clk_min, clk_hour, alm_min, alm_hour, ring, snoozing
   );
endinterface

// File: rtl/time_alarm_counter.sv
// rtl/time_alarm_counter.sv - clock/alarm minute-hour counters with ring/snooze FSM (option: ALARM_SNOOZE_LIMIT_EN)
module time_alarm_counter #(
   parameter int RING_MIN   = 5,
   parameter int SNOOZE_MIN = 9
) (
   input  logic                 ck,
   input  logic                 reset,
   time_alarm_counter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   logic [5:0] clk_min_q, clk_min_d, alm_min_q, alm_min_d;
   logic [4:0] clk_hour_q, clk_hour_d, alm_hour_q, alm_hour_d;
   logic       upd_q, upd_d;
   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic       ring_q, snoozing_q;
   logic       trigger;
   logic       snooze_ok;

   // One minute/hour set: minute wrap carries into the hour, hour sums both increments mod 24
   function automatic logic [10:0] bump(input logic [5:0] m, input logic [4:0] h,
                                        input logic up_m, input logic up_h);
      logic       carry;
      logic [5:0] m_n;
      logic [4:0] h_n;
      carry = up_m && (m == 6'd59);
      if (carry) m_n = 6'd0;
      else       m_n = m + {5'd0, up_m};
      h_n = h + {4'd0, up_h} + {4'd0, carry};
      if (h_n >= 5'd24) h_n = h_n - 5'd24;
      return {h_n, m_n};
   endfunction

   // Next values of both independent time sets and the clock-updated flag
   always_comb begin
      {clk_hour_d, clk_min_d} = bump(clk_min_q, clk_hour_q, bus.up_clock60, bus.up_clock_h);
      {alm_hour_d, alm_min_d} = bump(alm_min_q, alm_hour_q, bus.up_alarm60, bus.up_alarm_h);
      upd_d = bus.up_clock60 | bus.up_clock_h;
   end

   // Match is only looked at the cycle after a clock update, so alarm edits never fire it
   assign trigger = upd_q & bus.alarm_en & (clk_min_q == alm_min_q) & (clk_hour_q == alm_hour_q);

`ifdef ALARM_SNOOZE_LIMIT_EN
   logic [1:0] snz_q, snz_d;
   assign snooze_ok = (snz_q != 2'd3);
`else
   assign snooze_ok = 1'b1;
`endif

   // Ring/snooze next state; tick counter restarts on every state entry
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_d   = snz_q;
`endif
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = RING;
               tick_d  = 4'd0;
            end
         end
         RING: begin
            if (!bus.alarm_en || bus.stop) begin
               state_d = IDLE;
               tick_d  = 4'd0;
            end else if (bus.snooze && snooze_ok) begin
               state_d = SNOOZE;
               tick_d  = 4'd0;
`ifdef ALARM_SNOOZE_LIMIT_EN
               snz_d   = snz_q + 2'd1;
`endif
            end else if (bus.min) begin
               if (tick_q == 4'(RING_MIN - 1)) begin
                  state_d = IDLE;
                  tick_d  = 4'd0;
               end else begin
                  tick_d  = tick_q + 4'd1;
               end
            end
         end
         SNOOZE: begin
            if (!bus.alarm_en || bus.stop) begin
               state_d = IDLE;
               tick_d  = 4'd0;
            end else if (bus.min) begin
               if (tick_q == 4'(SNOOZE_MIN - 1)) begin
                  state_d = RING;
                  tick_d  = 4'd0;
               end else begin
                  tick_d  = tick_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = 4'd0;
         end
      endcase
`ifdef ALARM_SNOOZE_LIMIT_EN
      if (state_d == IDLE && state_q != IDLE) snz_d = 2'd0;
`endif
   end

   // State registers; ring/snoozing are flopped alongside the state they decode
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         clk_min_q  <= 6'd0;
         clk_hour_q <= 5'd0;
         alm_min_q  <= 6'd0;
         alm_hour_q <= 5'd0;
         upd_q      <= 1'b0;
         state_q    <= IDLE;
         tick_q     <= 4'd0;
         ring_q     <= 1'b0;
         snoozing_q <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
         snz_q      <= 2'd0;
`endif
      end else begin
         clk_min_q  <= clk_min_d;
         clk_hour_q <= clk_hour_d;
         alm_min_q  <= alm_min_d;
         alm_hour_q <= alm_hour_d;
         upd_q      <= upd_d;
         state_q    <= state_d;
         tick_q     <= tick_d;
         ring_q     <= (state_d == RING);
         snoozing_q <= (state_d == SNOOZE);
`ifdef ALARM_SNOOZE_LIMIT_EN
         snz_q      <= snz_d;
`endif
      end
   end

   assign bus.clk_min  = clk_min_q;
   assign bus.clk_hour = clk_hour_q;
   assign bus.alm_min  = alm_min_q;
   assign bus.alm_hour = alm_hour_q;
   assign bus.ring     = ring_q;
   assign bus.snoozing = snoozing_q;

endmodule

// File: tb/tb_time_alarm_counter.sv
// tb/tb_time_alarm_counter.sv - scoreboard bench for time_alarm_counter against a minutes-of-day model
module tb_time_alarm_counter;
   localparam int RING_MIN   = 5;
   localparam int SNOOZE_MIN = 9;
`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic ck = 1'b0;
   logic reset = 1'b1;
   always #5 ck = ~ck;

   time_alarm_counter_if bus();

   time_alarm_counter #(.RING_MIN(RING_MIN), .SNOOZE_MIN(SNOOZE_MIN)) dut (
      .ck    (ck),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [5:0] cm;
      logic [4:0] ch;
      logic [5:0] am;
      logic [4:0] ah;
      logic       r;
      logic       s;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: times as minutes of day, mode 0=idle 1=ring 2=snooze
   int m_clk, m_alm, m_mode, m_ticks, m_snz;
   bit m_upd;
   bit en;

   function automatic obs_t model_obs();
      obs_t o;
      o.cm = 6'(m_clk % 60);
      o.ch = 5'(m_clk / 60);
      o.am = 6'(m_alm % 60);
      o.ah = 5'(m_alm / 60);
      o.r  = (m_mode == 1);
      o.s  = (m_mode == 2);
      return o;
   endfunction

   function automatic void model_reset();
      m_clk = 0; m_alm = 0; m_mode = 0; m_ticks = 0; m_snz = 0; m_upd = 0;
   endfunction

   function automatic void model_step(bit uc, bit ua, bit uch, bit uah, bit mn, bit st, bit sn);
      bit trig;
      trig = m_upd && en && (m_clk == m_alm);
      case (m_mode)
         0: if (trig) begin m_mode = 1; m_ticks = 0; end
         1: begin
            if (!en || st) m_mode = 0;
            else if (sn && !(LIMIT && m_snz >= 3)) begin m_mode = 2; m_ticks = 0; m_snz++; end
            else if (mn) begin
               m_ticks++;
               if (m_ticks == RING_MIN) begin m_mode = 0; m_ticks = 0; end
            end
         end
         default: begin
            if (!en || st) m_mode = 0;
            else if (mn) begin
               m_ticks++;
               if (m_ticks == SNOOZE_MIN) begin m_mode = 1; m_ticks = 0; end
            end
         end
      endcase
      if (m_mode == 0) begin m_ticks = 0; m_snz = 0; end
      m_clk = (m_clk + int'(uc) + 60 * int'(uch)) % 1440;
      m_alm = (m_alm + int'(ua) + 60 * int'(uah)) % 1440;
      m_upd = uc | uch;
   endfunction

   task automatic drive(input bit uc, ua, uch, uah, mn, st, sn);
      bus.up_clock60 = uc;
      bus.up_alarm60 = ua;
      bus.up_clock_h = uch;
      bus.up_alarm_h = uah;
      bus.min        = mn;
      bus.stop       = st;
      bus.snooze     = sn;
      bus.alarm_en   = en;
   endtask

   // One clock of stimulus: drive at negedge, push the expected post-edge outputs
   task automatic step(input bit uc, ua, uch, uah, mn, st, sn);
      @(negedge ck);
      drive(uc, ua, uch, uah, mn, st, sn);
      model_step(uc, ua, uch, uah, mn, st, sn);
      exp_q.push_back(model_obs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      obs_t act;
      @(negedge ck);
      reset = 1'b1;
      #1;
      act = {bus.clk_min, bus.clk_hour, bus.alm_min, bus.alm_hour, bus.ring, bus.snoozing};
      checks++;
      if (act !== '0) begin
         errors++;
         $display("FAIL reset_async: got %h required 0", act);
      end
      @(negedge ck);
      en = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      model_reset();
   endtask

   // Loads both sets from 0:00 with parallel pulses (call right after reset)
   task automatic set_times(input int ch, cm, ah, am);
      en = 1'b0;
      for (int i = 0; i < 60; i++)
         step(i < cm, i < am, i < ch, i < ah, 0, 0, 0);
   endtask

   task automatic start_ring();
      do_reset();
      set_times(7, 29, 7, 30);
      en = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0);
      idle(2);
   endtask

   task automatic min_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 0, 0, 1, 0, 0);
         idle(1);
      end
   endtask

   // Monitor: every cycle with an outstanding expectation, compare once
   initial begin
      obs_t exp_o, act;
      forever begin
         @(posedge ck);
         #1;
         if (exp_q.size() > 0) begin
            exp_o = exp_q.pop_front();
            act = {bus.clk_min, bus.clk_hour, bus.alm_min, bus.alm_hour, bus.ring, bus.snoozing};
            checks++;
            if (act !== exp_o) begin
               errors++;
               $display("FAIL outputs @%0t: got clk %0d:%0d alm %0d:%0d ring %0b snz %0b required clk %0d:%0d alm %0d:%0d ring %0b snz %0b",
                        $time, act.ch, act.cm, act.ah, act.am, act.r, act.s,
                        exp_o.ch, exp_o.cm, exp_o.ah, exp_o.am, exp_o.r, exp_o.s);
            end
         end
      end
   end

   initial begin
      int c, a;
      en = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();

      // 60 minute pulses roll into the hour; alarm untouched
      do_reset();
      for (int i = 0; i < 60; i++) step(1, 0, 0, 0, 0, 0, 0);
      idle(1);

      // 23:59 with minute and hour pulse together -> 01:00
      do_reset();
      set_times(23, 59, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      idle(1);

      // Ring then self-cancel after RING_MIN ticks
      start_ring();
      min_ticks(RING_MIN);
      idle(2);

      // Snooze, re-ring after SNOOZE_MIN, stop+snooze together
      start_ring();
      step(0, 0, 0, 0, 0, 0, 1);
      min_ticks(SNOOZE_MIN);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(2);

      // Drop alarm_en while ringing
      start_ring();
      en = 1'b0;
      idle(2);

      // Alarm edited onto the clock time never rings
      do_reset();
      set_times(7, 30, 7, 29);
      en = 1'b1;
      step(0, 1, 0, 0, 0, 0, 0);
      idle(3);

      // Four snooze rounds (4th ignored only with the limit)
      start_ring();
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         idle(1);
         if (bus.snoozing) min_ticks(SNOOZE_MIN);
      end
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);

      // Reset in the middle of ringing
      start_ring();
      idle(1);
      do_reset();
      idle(1);

      // Random traffic around a nearby alarm
      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         c = $urandom_range(0, 1439);
         a = (c + $urandom_range(0, 150)) % 1440;
         set_times(c / 60, c % 60, a / 60, a % 60);
         en = 1'b1;
         for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 99) == 0) en = ~en;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 14) == 0);
         end
      end

      repeat (3) @(negedge ck);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drained: got %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
